instr_loader: RTL

- Receives a framed program image over the UART receive byte stream and assembles each pair of bytes into a 16-bit instruction word.
- Checks the opcode field [15:12] of every word against the defined instruction set and writes the words sequentially into instruction memory.
- Holds the CPU pipeline stalled for the whole load.
- Acts as the writer/encoder end feeding the opcode decoder. It sits between the UART RX block and the IMEM write port.

---
 rtl/instr_loader.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/instr_loader.sv
// Program image loader: assembles UART RX bytes into 16-bit instructions,
// screens opcodes, writes IMEM sequentially and stalls the CPU during a load.
module instr_loader #(
    parameter int          ADDR_W      = 6,
    parameter int          TIMEOUT_CYC = 50000,
    parameter logic [7:0]  START_BYTE  = 8'hA5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic [1:0]        load_err,
    output logic              bad_opcode
);

    // state   | meaning
    // S_IDLE  | waiting for START_BYTE, CPU free-running
    // S_COUNT | expecting word count N
    // S_HI    | expecting high byte of next word
    // S_LO    | expecting low byte; word written on the following clock
    // S_CHK   | expecting XOR checksum of all data bytes

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_CHECKSUM = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_OVERFLOW = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_HI,
        S_LO,
        S_CHK
    } state_t;

    state_t            state;
    logic [7:0]        hi_byte;
    logic [7:0]        n_words;
    logic [ADDR_W-1:0] idx;
    logic [7:0]        chk_acc;
    logic [TMR_W-1:0]  tmr;

    logic [3:0]  lo_opcode;
    logic        lo_illegal;
    logic        lo_last;
    logic [15:0] lo_word;

    always_comb begin
        lo_opcode  = hi_byte[7:4];
        lo_illegal = (lo_opcode >= 4'hB) && (lo_opcode <= 4'hE);
        lo_word    = lo_illegal ? 16'hF000 : {hi_byte, rx_data};
        lo_last    = ((int'(idx) + 1) == int'(n_words));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            hi_byte    <= '0;
            n_words    <= '0;
            idx        <= '0;
            chk_acc    <= '0;
            tmr        <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= ERR_NONE;
            bad_opcode <= 1'b0;
        end else begin
            imem_we   <= 1'b0;
            load_done <= 1'b0;

            // Idle-gap timer: reloads on every byte, counts down between bytes
            if (state != S_IDLE) begin
                if (rx_valid) begin
                    tmr <= TMR_LOAD;
                end else if (tmr != '0) begin
                    tmr <= tmr - TMR_W'(1);
                end
            end

            case (state)
                S_IDLE: begin
                    if (rx_valid && (rx_data == START_BYTE)) begin
                        state      <= S_COUNT;
                        cpu_hold   <= 1'b1;
                        load_err   <= ERR_NONE;
                        bad_opcode <= 1'b0;
                        chk_acc    <= '0;
                        idx        <= '0;
                        tmr        <= TMR_LOAD;
                    end
                end

                S_COUNT: begin
                    if (rx_valid) begin
                        if (rx_data == 8'h00) begin
                            state    <= S_IDLE;
                            cpu_hold <= 1'b0;
                        end else if (int'(rx_data) > DEPTH) begin
                            state    <= S_IDLE;
                            cpu_hold <= 1'b0;
                            load_err <= ERR_OVERFLOW;
                        end else begin
                            n_words <= rx_data;
                            state   <= S_HI;
                        end
                    end
                end

                S_HI: begin
                    if (rx_valid) begin
                        hi_byte <= rx_data;
                        chk_acc <= chk_acc ^ rx_data;
                        state   <= S_LO;
                    end
                end

                S_LO: begin
                    if (rx_valid) begin
                        chk_acc    <= chk_acc ^ rx_data;
                        imem_we    <= 1'b1;
                        imem_addr  <= idx;
                        imem_wdata <= lo_word;
                        idx        <= idx + ADDR_W'(1);
                        if (lo_illegal) begin
                            bad_opcode <= 1'b1;
                        end
                        state <= lo_last ? S_CHK : S_HI;
                    end
                end

                S_CHK: begin
                    if (rx_valid) begin
                        state    <= S_IDLE;
                        cpu_hold <= 1'b0;
                        if (rx_data == chk_acc) begin
                            load_done <= 1'b1;
                        end else begin
                            load_err <= ERR_CHECKSUM;
                        end
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    cpu_hold <= 1'b0;
                end
            endcase

            if ((state != S_IDLE) && !rx_valid && (tmr == '0)) begin
                state    <= S_IDLE;
                cpu_hold <= 1'b0;
                load_err <= ERR_TIMEOUT;
            end
        end
    end

endmodule
